// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg: shared state encoding and counter sizing for the stream framer.
package stream_framer_pkg;

    typedef enum logic {IDLE, ACTIVE} framer_state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: 0..MAX counter; clr restarts from zero and may combine with inc in the same cycle.
module wrap_counter
    import stream_framer_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W = cnt_width(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] base;
    logic [W-1:0] nxt;

    always_comb begin
        base = clr ? '0 : cnt;
        nxt  = inc ? ((base == LAST) ? '0 : base + 1'b1) : base;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= nxt;

    assign at_max = (cnt == LAST);

endmodule

// File: rtl/stream_framer.sv
// stream_framer: regenerates sop/eop/sof/eof framing for a bare pixel stream and flags frame-sync errors.
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    input  logic                         sof_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         data_valid_o,
    output logic                         sop_o,
    output logic                         eop_o,
    output logic                         sof_o,
    output logic                         eof_o,
    output logic                         sync_err_o,
    output logic [15:0]                  frame_cnt_o
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    framer_state_t state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic col_last, row_last;
    logic start, accept, resync, sop, eop, eof, sync_err;

    // A sof beat is always treated as col 0, row 0, whatever the counters hold.
    assign start = valid_i && sof_i;

    wrap_counter #(.MAX(IMG_WIDTH - 1)) u_col (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (accept),
        .clr    (start),
        .cnt    (col),
        .at_max (col_last)
    );

    wrap_counter #(.MAX(IMG_HEIGHT - 1)) u_row (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (accept && eop),
        .clr    (start),
        .cnt    (row),
        .at_max (row_last)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = accept ? (eof ? IDLE : ACTIVE) : state;

    always_comb begin
        accept   = valid_i && (sof_i || state == ACTIVE);
        resync   = start && state == ACTIVE && !(col == '0 && row == '0);
        sop      = start || col == '0;
        eop      = (IMG_WIDTH == 1) || (!start && col_last);
        eof      = eop && ((IMG_HEIGHT == 1) || (!start && row_last));
        sync_err = valid_i && ((state == IDLE) ? !sof_i : resync);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            sync_err_o   <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            if (accept) data_o <= data_i;
            data_valid_o <= accept;
            sop_o        <= accept && sop;
            eop_o        <= accept && eop;
            sof_o        <= accept && start;
            eof_o        <= accept && eof;
            sync_err_o   <= sync_err;
            if (accept && eof) frame_cnt_o <= frame_cnt_o + 16'd1;
        end

endmodule
